cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single result-writeback bus (CDB) into the ROB between the ALU and the LSB.
//  Each source pushes results into its own small FIFO; a round-robin scheduler drains one entry per cycle onto a registered CDB.
//  The CDB is read by the ROB (mark can_commit, store data and branch outcome) and by the RS/LSB (wake-up).
//  rollback flushes all in-flight results.
// PARAMETERS
//  ROB_ID_W   4   ROB index width
//  DATA_W     32  result data width
//  ADDR_W     32  branch target width
//  FIFO_DEPTH 2   entries per source FIFO; power of two, >=2
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, asynchronous, active-high
//  rdy          in   1        global enable; when low, all state holds
//  rollback     in   1        mispredict flush
//  alu_valid    in   1        ALU result present
//  alu_ready    out  1        ALU FIFO can accept this cycle
//  alu_rob_id   in   ROB_ID_W destination ROB entry
//  alu_data     in   DATA_W   result value
//  alu_is_jump  in   1        branch/JALR actually taken
//  alu_jump_pc  in   ADDR_W   resolved target
//  lsb_valid    in   1        load/store result present
//  lsb_ready    out  1        LSB FIFO can accept this cycle
//  lsb_rob_id   in   ROB_ID_W destination ROB entry
//  lsb_data     in   DATA_W   loaded value
//  cdb_valid    out  1        broadcast valid
//  cdb_src      out  1        0 = ALU, 1 = LSB
//  cdb_rob_id   out  ROB_ID_W broadcast ROB entry
//  cdb_data     out  DATA_W   broadcast value
//  cdb_is_jump  out  1        taken flag; 0 for LSB entries
//  cdb_jump_pc  out  ADDR_W   target; 0 for LSB entries
// BEHAVIOUR
//  Reset:
//  - Clears both FIFOs (rd/wr ptr=0, count=0).
//  - Sets last_grant=1 (LSB), so the ALU wins the first tie.
//  - All cdb_* outputs are 0.
//  Ready and accept:
//  - x_ready = rdy && !rollback && (count_x < FIFO_DEPTH).
//  - Combinational from registered count only; there is no pass-through when full, even if a pop occurs in the same cycle.
//  - An accept is x_valid && x_ready; the entry is written at wr_ptr and wr_ptr increments mod FIFO_DEPTH.
//  Arbitration (every edge with rdy=1 and rollback=0):
//  - Candidates are non-empty FIFOs, evaluated on pre-edge counts.
//  - One candidate: grant it.
//  - Both: grant the source != last_grant.
//  - Granted head is copied into the cdb_* registers; cdb_valid<=1, cdb_src<=grant, rd_ptr++, last_grant<=grant.
//  - No candidate: cdb_valid<=0 and the other cdb fields hold.
//  Latency:
//  - A result accepted at edge E0 into an empty, uncontested FIFO appears on the CDB after edge E1.
//  - cdb_valid is high for exactly one cycle per entry.
//  Simultaneous push and pop on one FIFO: count is unchanged and both pointers advance.
//  Throughput: one broadcast per cycle; a continuously contended source is served at least every 2nd cycle.
//  rollback=1 at an edge (rdy=1):
//  - Both FIFOs are emptied and cdb_valid<=0.
//  - Same-cycle inputs are dropped (ready is low).
//  - last_grant holds.
//  rdy=0: no push, no pop, all registers hold, ready is low.
//  Async rst mid-operation: immediate return to reset state; pending results are lost.
// TESTING
//  1. ALU result id=3, data=0x55 with idle LSB:
//     - After edge 1, ready stays 1.
//     - After edge 2: cdb_valid=1, src=0, rob_id=3, data=0x55; it deasserts after edge 3.
//  2. ALU and LSB both push every cycle for 6 cycles:
//     - The CDB alternates ALU, LSB, ALU, ..., starting with ALU.
//     - Each ready drops while its FIFO holds 2; no entry is lost or duplicated.
//  3. Fill the ALU FIFO (2 entries) with LSB idle:
//     - alu_ready=0 while count=2.
//     - A push offered when the pop frees space is accepted only on the following cycle.
//  4. rollback with both FIFOs holding 2 entries:
//     - Next cycle cdb_valid=0 and both readies return to 1.
//     - A result pushed after the rollback is broadcast 2 edges later.
//  5. Taken ALU branch id=7, jump_pc=0x1000 interleaved with LSB id=2:
//     - ALU broadcast has is_jump=1, pc=0x1000.
//     - LSB broadcast has is_jump=0, pc=0.
//  6. Drop rdy for 3 cycles with entries pending, then assert rst asynchronously mid-cycle:
//     - While rdy=0, the outputs hold.
//     - rst clears every output before the next clk edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Result-writeback (CDB) arbiter: per-source FIFOs for ALU and LSB results, drained
// one entry per cycle by a round-robin scheduler onto a registered broadcast bus.
module cdb_arbiter #(
    parameter int unsigned ROB_ID_W   = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                alu_is_jump,
    input  logic [ADDR_W-1:0]   alu_jump_pc,
    input  logic                lsb_valid,
    output logic                lsb_ready,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_data,
    output logic                cdb_valid,
    output logic                cdb_src,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_data,
    output logic                cdb_is_jump,
    output logic [ADDR_W-1:0]   cdb_jump_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   data;
        logic                is_jump;
        logic [ADDR_W-1:0]   jump_pc;
    } alu_ent_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   data;
    } lsb_ent_t;

    alu_ent_t            alu_mem_q [FIFO_DEPTH];
    lsb_ent_t            lsb_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]    alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
    logic [PTR_W-1:0]    lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
    logic [CNT_W-1:0]    alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
    src_e                last_grant_q, last_grant_d;

    logic                cdb_valid_q, cdb_valid_d;
    src_e                cdb_src_q, cdb_src_d;
    logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_W-1:0]   cdb_data_q, cdb_data_d;
    logic                cdb_is_jump_q, cdb_is_jump_d;
    logic [ADDR_W-1:0]   cdb_jump_pc_q, cdb_jump_pc_d;

    logic                alu_push, lsb_push, alu_pop, lsb_pop;
    logic                alu_has, lsb_has, grant_en;
    src_e                grant;
    alu_ent_t            alu_head;
    lsb_ent_t            lsb_head;

    // Ready depends only on registered occupancy: a full FIFO never passes through.
    always_comb begin
        alu_ready = rdy && !rollback && (alu_cnt_q < CNT_W'(FIFO_DEPTH));
        lsb_ready = rdy && !rollback && (lsb_cnt_q < CNT_W'(FIFO_DEPTH));
        alu_push  = alu_valid && alu_ready;
        lsb_push  = lsb_valid && lsb_ready;
        alu_has   = (alu_cnt_q != '0);
        lsb_has   = (lsb_cnt_q != '0);
        grant_en  = rdy && !rollback && (alu_has || lsb_has);
        grant     = (lsb_has && (!alu_has || last_grant_q == SRC_ALU)) ? SRC_LSB : SRC_ALU;
        alu_pop   = grant_en && (grant == SRC_ALU);
        lsb_pop   = grant_en && (grant == SRC_LSB);
        alu_head  = alu_mem_q[alu_rd_q];
        lsb_head  = lsb_mem_q[lsb_rd_q];
    end

    always_comb begin
        alu_wr_d      = alu_wr_q;
        alu_rd_d      = alu_rd_q;
        alu_cnt_d     = alu_cnt_q;
        lsb_wr_d      = lsb_wr_q;
        lsb_rd_d      = lsb_rd_q;
        lsb_cnt_d     = lsb_cnt_q;
        last_grant_d  = last_grant_q;
        cdb_valid_d   = cdb_valid_q;
        cdb_src_d     = cdb_src_q;
        cdb_rob_id_d  = cdb_rob_id_q;
        cdb_data_d    = cdb_data_q;
        cdb_is_jump_d = cdb_is_jump_q;
        cdb_jump_pc_d = cdb_jump_pc_q;

        if (rdy) begin
            if (rollback) begin
                alu_wr_d    = '0;
                alu_rd_d    = '0;
                alu_cnt_d   = '0;
                lsb_wr_d    = '0;
                lsb_rd_d    = '0;
                lsb_cnt_d   = '0;
                cdb_valid_d = 1'b0;
            end else begin
                if (alu_push) alu_wr_d = alu_wr_q + PTR_W'(1);
                if (lsb_push) lsb_wr_d = lsb_wr_q + PTR_W'(1);
                if (alu_pop)  alu_rd_d = alu_rd_q + PTR_W'(1);
                if (lsb_pop)  lsb_rd_d = lsb_rd_q + PTR_W'(1);
                alu_cnt_d   = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);
                lsb_cnt_d   = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
                cdb_valid_d = grant_en;
                if (grant_en) begin
                    last_grant_d = grant;
                    cdb_src_d    = grant;
                    if (grant == SRC_ALU) begin
                        cdb_rob_id_d  = alu_head.rob_id;
                        cdb_data_d    = alu_head.data;
                        cdb_is_jump_d = alu_head.is_jump;
                        cdb_jump_pc_d = alu_head.jump_pc;
                    end else begin
                        cdb_rob_id_d  = lsb_head.rob_id;
                        cdb_data_d    = lsb_head.data;
                        cdb_is_jump_d = 1'b0;
                        cdb_jump_pc_d = '0;
                    end
                end
            end
        end
    end

    // FIFO storage needs no reset: the pointers and counts define what is live.
    always_ff @(posedge clk) begin
        if (alu_push) alu_mem_q[alu_wr_q] <= '{alu_rob_id, alu_data, alu_is_jump, alu_jump_pc};
        if (lsb_push) lsb_mem_q[lsb_wr_q] <= '{lsb_rob_id, lsb_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wr_q      <= '0;
            alu_rd_q      <= '0;
            alu_cnt_q     <= '0;
            lsb_wr_q      <= '0;
            lsb_rd_q      <= '0;
            lsb_cnt_q     <= '0;
            last_grant_q  <= SRC_LSB;
            cdb_valid_q   <= 1'b0;
            cdb_src_q     <= SRC_ALU;
            cdb_rob_id_q  <= '0;
            cdb_data_q    <= '0;
            cdb_is_jump_q <= 1'b0;
            cdb_jump_pc_q <= '0;
        end else begin
            alu_wr_q      <= alu_wr_d;
            alu_rd_q      <= alu_rd_d;
            alu_cnt_q     <= alu_cnt_d;
            lsb_wr_q      <= lsb_wr_d;
            lsb_rd_q      <= lsb_rd_d;
            lsb_cnt_q     <= lsb_cnt_d;
            last_grant_q  <= last_grant_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_src_q     <= cdb_src_d;
            cdb_rob_id_q  <= cdb_rob_id_d;
            cdb_data_q    <= cdb_data_d;
            cdb_is_jump_q <= cdb_is_jump_d;
            cdb_jump_pc_q <= cdb_jump_pc_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_src     = cdb_src_q;
    assign cdb_rob_id  = cdb_rob_id_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_is_jump = cdb_is_jump_q;
    assign cdb_jump_pc = cdb_jump_pc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-computed vector table, directed corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clk, rst, rdy, rollback;
    logic        alu_valid, alu_ready, alu_is_jump;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_data, alu_jump_pc;
    logic        lsb_valid, lsb_ready;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_data;
    logic        cdb_valid, cdb_src, cdb_is_jump;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_data, cdb_jump_pc;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.ROB_ID_W(4), .DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
        .alu_data(alu_data), .alu_is_jump(alu_is_jump), .alu_jump_pc(alu_jump_pc),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id),
        .lsb_data(lsb_data),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_id(cdb_rob_id),
        .cdb_data(cdb_data), .cdb_is_jump(cdb_is_jump), .cdb_jump_pc(cdb_jump_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per source plus the broadcast it should show.
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        j;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq_a[$];
    ent_t        mq_l[$];
    bit          m_last;
    bit          m_v, m_src, m_j;
    logic [3:0]  m_id;
    logic [31:0] m_data, m_pc;

    task automatic model_reset();
        mq_a.delete();
        mq_l.delete();
        m_last = 1'b1;
        m_v = 1'b0; m_src = 1'b0; m_j = 1'b0;
        m_id = '0; m_data = '0; m_pc = '0;
    endtask

    task automatic model_step();
        bit   ar, lr, ca, cl, g;
        ent_t e;
        if (!rdy) return;
        if (rollback) begin
            mq_a.delete();
            mq_l.delete();
            m_v = 1'b0;
            return;
        end
        ar = (mq_a.size() < DEPTH);
        lr = (mq_l.size() < DEPTH);
        ca = (mq_a.size() > 0);
        cl = (mq_l.size() > 0);
        if (ca || cl) begin
            g = (ca && cl) ? !m_last : cl;
            e = g ? mq_l.pop_front() : mq_a.pop_front();
            m_v = 1'b1; m_src = g; m_last = g;
            m_id = e.id; m_data = e.data; m_j = e.j; m_pc = e.pc;
        end else begin
            m_v = 1'b0;
        end
        if (alu_valid && ar) mq_a.push_back('{alu_rob_id, alu_data, alu_is_jump, alu_jump_pc});
        if (lsb_valid && lr) mq_l.push_back('{lsb_rob_id, lsb_data, 1'b0, 32'h0});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model_ready(input string tag);
        chk({tag, " alu_ready"}, 64'(alu_ready), 64'(rdy && !rollback && mq_a.size() < DEPTH));
        chk({tag, " lsb_ready"}, 64'(lsb_ready), 64'(rdy && !rollback && mq_l.size() < DEPTH));
    endtask

    task automatic chk_model_cdb(input string tag);
        chk({tag, " cdb_valid"},   64'(cdb_valid),   64'(m_v));
        chk({tag, " cdb_src"},     64'(cdb_src),     64'(m_src));
        chk({tag, " cdb_rob_id"},  64'(cdb_rob_id),  64'(m_id));
        chk({tag, " cdb_data"},    64'(cdb_data),    64'(m_data));
        chk({tag, " cdb_is_jump"}, 64'(cdb_is_jump), 64'(m_j));
        chk({tag, " cdb_jump_pc"}, 64'(cdb_jump_pc), 64'(m_pc));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic set_alu(input bit v, input logic [3:0] id, input logic [31:0] d,
                           input bit j, input logic [31:0] pc);
        alu_valid = v; alu_rob_id = id; alu_data = d; alu_is_jump = j; alu_jump_pc = pc;
    endtask

    task automatic set_lsb(input bit v, input logic [3:0] id, input logic [31:0] d);
        lsb_valid = v; lsb_rob_id = id; lsb_data = d;
    endtask

    task automatic idle();
        set_alu(1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
        set_lsb(1'b0, 4'h0, 32'h0);
    endtask

    typedef struct {
        bit          rst;
        bit          av;
        logic [3:0]  aid;
        logic [31:0] ad;
        bit          aj;
        logic [31:0] apc;
        bit          lv;
        logic [3:0]  lid;
        logic [31:0] ld;
        bit          ear, elr, ev, esrc;
        logic [3:0]  eid;
        logic [31:0] ed;
        bit          ej;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t mkv(bit r, bit av, logic [3:0] aid, logic [31:0] ad, bit aj,
                                 logic [31:0] apc, bit lv, logic [3:0] lid, logic [31:0] ld,
                                 bit ear, bit elr, bit ev, bit esrc, logic [3:0] eid,
                                 logic [31:0] ed, bit ej, logic [31:0] epc);
        vec_t v;
        v.rst = r; v.av = av; v.aid = aid; v.ad = ad; v.aj = aj; v.apc = apc;
        v.lv = lv; v.lid = lid; v.ld = ld; v.ear = ear; v.elr = elr; v.ev = ev;
        v.esrc = esrc; v.eid = eid; v.ed = ed; v.ej = ej; v.epc = epc;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        chk("reset cdb_valid",   64'(cdb_valid),   64'h0);
        chk("reset cdb_src",     64'(cdb_src),     64'h0);
        chk("reset cdb_rob_id",  64'(cdb_rob_id),  64'h0);
        chk("reset cdb_data",    64'(cdb_data),    64'h0);
        chk("reset cdb_is_jump", 64'(cdb_is_jump), 64'h0);
        chk("reset cdb_jump_pc", 64'(cdb_jump_pc), 64'h0);
        chk("reset alu_ready",   64'(alu_ready),   64'h1);
        rst = 1'b0;
        #1;

        // Single ALU result: two-edge latency, one-cycle valid.
        vt.push_back(mkv(1, 1, 4'd3, 32'h55, 0, 0, 0, 0, 0,      1, 1, 0, 0, 4'd0, 32'h0, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 1, 1, 0, 4'd3, 32'h55, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 1, 0, 0, 4'd3, 32'h55, 0, 0));
        // Both sources push every cycle (retry until accepted): strict alternation from ALU.
        vt.push_back(mkv(1, 1, 4'd1, 32'hA1, 0, 0, 1, 4'd9,  32'hB1, 1, 1, 0, 0, 4'd0,  32'h0,  0, 0));
        vt.push_back(mkv(0, 1, 4'd2, 32'hA2, 0, 0, 1, 4'd10, 32'hB2, 1, 1, 1, 0, 4'd1,  32'hA1, 0, 0));
        vt.push_back(mkv(0, 1, 4'd3, 32'hA3, 0, 0, 1, 4'd11, 32'hB3, 1, 0, 1, 1, 4'd9,  32'hB1, 0, 0));
        vt.push_back(mkv(0, 1, 4'd4, 32'hA4, 0, 0, 1, 4'd11, 32'hB3, 0, 1, 1, 0, 4'd2,  32'hA2, 0, 0));
        vt.push_back(mkv(0, 1, 4'd4, 32'hA4, 0, 0, 1, 4'd12, 32'hB4, 1, 0, 1, 1, 4'd10, 32'hB2, 0, 0));
        vt.push_back(mkv(0, 1, 4'd5, 32'hA5, 0, 0, 1, 4'd12, 32'hB4, 0, 1, 1, 0, 4'd3,  32'hA3, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                  1, 0, 1, 1, 4'd11, 32'hB3, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                  1, 1, 1, 0, 4'd4,  32'hA4, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                  1, 1, 1, 1, 4'd12, 32'hB4, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                  1, 1, 0, 1, 4'd12, 32'hB4, 0, 0));
        // Taken branch vs LSB result: LSB broadcast carries no jump info.
        vt.push_back(mkv(1, 1, 4'd7, 32'h77, 1, 32'h1000, 1, 4'd2, 32'h22, 1, 1, 0, 0, 4'd0, 32'h0,  0, 32'h0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                        1, 1, 1, 0, 4'd7, 32'h77, 1, 32'h1000));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                        1, 1, 1, 1, 4'd2, 32'h22, 0, 32'h0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,                        1, 1, 0, 1, 4'd2, 32'h22, 0, 32'h0));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            set_alu(vt[i].av, vt[i].aid, vt[i].ad, vt[i].aj, vt[i].apc);
            set_lsb(vt[i].lv, vt[i].lid, vt[i].ld);
            #1;
            chk($sformatf("vec%0d alu_ready", i), 64'(alu_ready), 64'(vt[i].ear));
            chk($sformatf("vec%0d lsb_ready", i), 64'(lsb_ready), 64'(vt[i].elr));
            tick();
            chk($sformatf("vec%0d cdb_valid", i),   64'(cdb_valid),   64'(vt[i].ev));
            chk($sformatf("vec%0d cdb_src", i),     64'(cdb_src),     64'(vt[i].esrc));
            chk($sformatf("vec%0d cdb_rob_id", i),  64'(cdb_rob_id),  64'(vt[i].eid));
            chk($sformatf("vec%0d cdb_data", i),    64'(cdb_data),    64'(vt[i].ed));
            chk($sformatf("vec%0d cdb_is_jump", i), 64'(cdb_is_jump), 64'(vt[i].ej));
            chk($sformatf("vec%0d cdb_jump_pc", i), 64'(cdb_jump_pc), 64'(vt[i].epc));
        end

        // Full ALU FIFO: no pass-through; retried push lands one cycle after the pop.
        do_reset();
        set_alu(1, 4'd1, 32'hA1, 0, 0); set_lsb(1, 4'd9, 32'hB1); #1; tick();
        set_alu(1, 4'd2, 32'hA2, 0, 0); set_lsb(0, 0, 0); #1; tick();
        chk("full cdb A1", 64'(cdb_rob_id), 64'd1);
        set_alu(1, 4'd3, 32'hA3, 0, 0); #1; tick();
        chk("full cdb L1 src", 64'(cdb_src), 64'd1);
        set_alu(1, 4'd4, 32'hA4, 0, 0); #1;
        chk("full alu_ready", 64'(alu_ready), 64'd0);
        tick();
        chk("full cdb A2", 64'(cdb_rob_id), 64'd2);
        chk("full alu_ready after pop", 64'(alu_ready), 64'd1);
        tick();
        chk("full cdb A3", 64'(cdb_rob_id), 64'd3);
        idle(); #1; tick();
        chk("full cdb A4 id", 64'(cdb_rob_id), 64'd4);
        chk("full cdb A4 valid", 64'(cdb_valid), 64'd1);
        tick();
        chk("full drained valid", 64'(cdb_valid), 64'd0);

        // Rollback with entries pending; same-cycle pushes are dropped.
        do_reset();
        set_alu(1, 4'd1, 32'hA1, 0, 0); set_lsb(1, 4'd9, 32'hB1); #1; tick();
        set_alu(1, 4'd2, 32'hA2, 0, 0); set_lsb(1, 4'd10, 32'hB2); #1; tick();
        chk("rb pre cdb A1", 64'(cdb_rob_id), 64'd1);
        rollback = 1'b1;
        set_alu(1, 4'd3, 32'hA3, 0, 0); set_lsb(1, 4'd11, 32'hB3); #1;
        chk("rb alu_ready low", 64'(alu_ready), 64'd0);
        chk("rb lsb_ready low", 64'(lsb_ready), 64'd0);
        tick();
        rollback = 1'b0; idle(); #1;
        chk("rb cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rb cdb_rob_id hold", 64'(cdb_rob_id), 64'd1);
        chk("rb alu_ready back", 64'(alu_ready), 64'd1);
        chk("rb lsb_ready back", 64'(lsb_ready), 64'd1);
        set_alu(1, 4'd5, 32'hA5, 0, 0); tick();
        chk("rb flushed valid", 64'(cdb_valid), 64'd0);
        idle(); #1; tick();
        chk("rb new valid", 64'(cdb_valid), 64'd1);
        chk("rb new id", 64'(cdb_rob_id), 64'd5);
        set_alu(1, 4'd6, 32'hA6, 0, 0); set_lsb(1, 4'd14, 32'hB6); #1; tick();
        idle(); #1; tick();
        chk("rb tie src", 64'(cdb_src), 64'd1);
        chk("rb tie id", 64'(cdb_rob_id), 64'd14);

        // rdy low freezes everything; async reset mid-cycle clears outputs immediately.
        do_reset();
        set_alu(1, 4'd1, 32'hA1, 0, 0); set_lsb(1, 4'd9, 32'hB1); #1; tick();
        idle(); #1; tick();
        chk("stall pre valid", 64'(cdb_valid), 64'd1);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d alu_ready", k), 64'(alu_ready), 64'd0);
            chk($sformatf("stall%0d lsb_ready", k), 64'(lsb_ready), 64'd0);
            tick();
            chk($sformatf("stall%0d cdb_valid", k), 64'(cdb_valid), 64'd1);
            chk($sformatf("stall%0d cdb_rob_id", k), 64'(cdb_rob_id), 64'd1);
            chk($sformatf("stall%0d cdb_data", k), 64'(cdb_data), 64'hA1);
        end
        rdy = 1'b1;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst cdb_valid",  64'(cdb_valid),  64'd0);
        chk("arst cdb_rob_id", 64'(cdb_rob_id), 64'd0);
        chk("arst cdb_data",   64'(cdb_data),   64'd0);
        chk("arst cdb_src",    64'(cdb_src),    64'd0);
        #2;
        rst = 1'b0;
        #1;
        tick();
        chk("arst lost valid", 64'(cdb_valid), 64'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 24) == 0);
            set_alu(($urandom_range(0, 9) < 6), 4'($urandom), $urandom,
                    1'($urandom), $urandom);
            set_lsb(($urandom_range(0, 9) < 6), 4'($urandom), $urandom);
            #1;
            chk_model_ready($sformatf("rnd%0d", n));
            tick();
            chk_model_cdb($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
